// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the architectural PC, issues one instruction fetch at a time
// over a req/ack handshake, presents fetched words to decode and handles branch redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_INCR     = 4,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        flush
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StFlush
  } state_e;

  localparam logic [31:0] Incr      = 32'(PC_INCR);
  localparam logic [3:0]  FlushLast = 4'(FLUSH_DEPTH - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        pending_q;
  logic [3:0]  flush_cnt_q;
  logic        boot_done_q;
  logic [31:0] target;

  assign target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_inst     <= '0;
      flush       <= 1'b0;
      pending_q   <= 1'b0;
      flush_cnt_q <= '0;
      boot_done_q <= 1'b0;
    end else if (redirect_valid && state_q != StIdle) begin
      // Redirect wins over stall and ack; an unacknowledged request keeps its address
      // and is drained in FLUSH, a coinciding ack is simply dropped.
      pc_q        <= target;
      if_valid    <= 1'b0;
      flush       <= 1'b1;
      flush_cnt_q <= FlushLast;
      state_q     <= StFlush;
      if (imem_req) begin
        if (imem_ack) begin
          imem_req  <= 1'b0;
          pending_q <= 1'b0;
        end else begin
          pending_q <= 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // Spend one full cycle idle after reset release before the first fetch.
          boot_done_q <= 1'b1;
          if (boot_done_q) begin
            state_q   <= StReq;
            imem_req  <= 1'b1;
            imem_addr <= pc_q;
          end
        end
        StReq: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if_inst  <= imem_rdata;
            if_pc    <= pc_q;
            if_valid <= 1'b1;
            pc_q     <= pc_q + Incr;
            state_q  <= StHold;
          end
        end
        StHold: begin
          if (!stall) begin
            if_valid  <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= pc_q;
            state_q   <= StReq;
          end
        end
        StFlush: begin
          if (pending_q && imem_ack) begin
            pending_q <= 1'b0;
            imem_req  <= 1'b0;
          end
          if (flush_cnt_q != 4'd0) begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end else if (!pending_q) begin
            flush     <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= pc_q;
            state_q   <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed boot/stall/redirect/wrap/reset scenarios followed by
// randomized traffic checked against a transaction-level model of the fetch stream.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0000_0100;
  localparam int unsigned FLUSH_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 0;
  bit rand_lat = 1'b0;
  int wait_cnt;
  int cur_lat;

  pc_sequencer #(
    .RESET_PC   (RESET_PC),
    .PC_INCR    (4),
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Memory: acks cur_lat cycles after req rises (0 = same cycle), reset by the same rst_n.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
      cur_lat  = 0;
    end else if (!imem_req) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
      cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
    end else if (wait_cnt >= cur_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ack = 1'b0;
      wait_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({imem_req, if_valid, flush} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags: got %b want 000", {imem_req, if_valid, flush}); end
    n_cmp++; if ({if_pc, if_inst} !== 64'd0) begin n_err++;
      $display("FAIL reset_if: got %h want 0", {if_pc, if_inst}); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_err++;
      $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_boot();
    logic [31:0] exp;
    mem_lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;  // E0
    n_cmp++; if (imem_req !== 1'b0) begin n_err++;
      $display("FAIL boot_e0_idle: got req=%b want 0", imem_req); end
    @(posedge clk); #1;  // E1
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin n_err++;
      $display("FAIL boot_e1_req: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC); end
    @(posedge clk); #1;  // E2
    n_cmp++; if ({if_valid, if_pc, if_inst} !== {1'b1, RESET_PC, mem_word(RESET_PC)}) begin
      n_err++; $display("FAIL boot_e2_present: got %b/%h/%h want 1/%h/%h", if_valid, if_pc,
                        if_inst, RESET_PC, mem_word(RESET_PC)); end
    for (int i = 1; i <= 3; i++) begin
      exp = RESET_PC + 32'(4 * i);
      @(posedge clk); #1;
      n_cmp++; if (if_valid !== 1'b0) begin n_err++;
        $display("FAIL boot_gap%0d: got valid=%b want 0", i, if_valid); end
      @(posedge clk); #1;
      n_cmp++; if ({if_valid, if_pc, if_inst} !== {1'b1, exp, mem_word(exp)}) begin n_err++;
        $display("FAIL boot_seq%0d: got %b/%h want 1/%h", i, if_valid, if_pc, exp); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held  = RESET_PC + 32'hC;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({if_valid, imem_req, if_pc, if_inst} !== {2'b10, held, mem_word(held)}) begin
        n_err++; $display("FAIL stall_hold%0d: got %b%b/%h/%h want 10/%h/%h", i, if_valid,
                          imem_req, if_pc, if_inst, held, mem_word(held)); end
    end
    stall = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({if_valid, imem_req, imem_addr} !== {2'b01, held + 32'd4}) begin n_err++;
      $display("FAIL stall_release: got %b%b/%h want 01/%h", if_valid, imem_req, imem_addr,
               held + 32'd4); end
    @(posedge clk); #1;
    n_cmp++; if ({if_valid, if_pc} !== {1'b1, held + 32'd4}) begin n_err++;
      $display("FAIL stall_next: got %b/%h want 1/%h", if_valid, if_pc, held + 32'd4); end
  endtask

  task automatic test_redirect_pending();
    logic [31:0] old_addr;
    int flush_cycles;
    old_addr = RESET_PC + 32'h14;
    mem_lat  = 3;
    @(posedge clk); #1;
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, old_addr}) begin n_err++;
      $display("FAIL pend_req: got %b/%h want 1/%h", imem_req, imem_addr, old_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2003;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    flush_cycles   = 32'(flush);
    n_cmp++; if ({flush, if_valid, imem_req, imem_addr} !== {3'b101, old_addr}) begin n_err++;
      $display("FAIL pend_redirect: got %b%b%b/%h want 101/%h", flush, if_valid, imem_req,
               imem_addr, old_addr); end
    for (int i = 0; i < 12 && imem_req; i++) begin
      @(posedge clk); #1;
      flush_cycles += 32'(flush);
      n_cmp++; if (if_valid !== 1'b0 || (imem_req && imem_addr !== old_addr)) begin n_err++;
        $display("FAIL pend_drain: got valid=%b addr=%h want 0/%h", if_valid, imem_addr,
                 old_addr); end
    end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++;
      $display("FAIL pend_ack_timeout: got req=%b want 0", imem_req); end
    mem_lat = 0;
    for (int i = 0; i < 12 && !imem_req; i++) begin
      @(posedge clk); #1;
      flush_cycles += 32'(flush);
      n_cmp++; if (if_valid !== 1'b0) begin n_err++;
        $display("FAIL pend_squash: got valid=%b want 0", if_valid); end
    end
    n_cmp++; if ({imem_req, flush, imem_addr} !== {2'b10, 32'h0000_2000}) begin n_err++;
      $display("FAIL pend_target: got %b%b/%h want 10/00002000", imem_req, flush, imem_addr); end
    n_cmp++; if (flush_cycles < 2) begin n_err++;
      $display("FAIL pend_flush_len: got %0d want >=2", flush_cycles); end
    @(posedge clk); #1;
    n_cmp++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h2000, mem_word(32'h2000)}) begin
      n_err++; $display("FAIL pend_present: got %b/%h want 1/00002000", if_valid, if_pc); end
  endtask

  task automatic test_redirect_ack();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !imem_req; i++) begin @(posedge clk); #1; end
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin n_err++;
      $display("FAIL ack_pre: got %b/%h want 1/00000040", imem_req, imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    n_cmp++; if ({if_valid, flush, imem_req} !== 3'b010) begin n_err++;
      $display("FAIL ack_discard: got %b%b%b want 010", if_valid, flush, imem_req); end
    for (int i = 0; i < 10 && !imem_req; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (if_valid !== 1'b0) begin n_err++;
        $display("FAIL ack_squash: got valid=%b want 0", if_valid); end
    end
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin n_err++;
      $display("FAIL ack_next_addr: got %b/%h want 1/00000080", imem_req, imem_addr); end
    @(posedge clk); #1;
    n_cmp++; if ({if_valid, if_pc} !== {1'b1, 32'h80}) begin n_err++;
      $display("FAIL ack_present: got %b/%h want 1/00000080", if_valid, if_pc); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    @(posedge clk); #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++;
      $display("FAIL b2b_first: got flush=%b want 1", flush); end
    redirect_pc = 32'h0000_0020;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    n_cmp++; if ({flush, imem_req} !== 2'b10) begin n_err++;
      $display("FAIL b2b_second: got %b%b want 10", flush, imem_req); end
    @(posedge clk); #1;
    n_cmp++; if ({flush, imem_req} !== 2'b10) begin n_err++;
      $display("FAIL b2b_restart: got %b%b want 10", flush, imem_req); end
    @(posedge clk); #1;
    n_cmp++; if ({flush, imem_req, imem_addr} !== {2'b01, 32'h20}) begin n_err++;
      $display("FAIL b2b_exit: got %b%b/%h want 01/00000020", flush, imem_req, imem_addr); end
    @(posedge clk); #1;
    n_cmp++; if ({if_valid, if_pc} !== {1'b1, 32'h20}) begin n_err++;
      $display("FAIL b2b_present: got %b/%h want 1/00000020", if_valid, if_pc); end
  endtask

  task automatic test_wrap_async_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !if_valid; i++) begin @(posedge clk); #1; end
    n_cmp++; if ({if_valid, if_pc} !== {1'b1, 32'hFFFF_FFFC}) begin n_err++;
      $display("FAIL wrap_top: got %b/%h want 1/fffffffc", if_valid, if_pc); end
    @(posedge clk); #1;
    for (int i = 0; i < 10 && !if_valid; i++) begin @(posedge clk); #1; end
    n_cmp++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h0, mem_word(32'h0)}) begin n_err++;
      $display("FAIL wrap_zero: got %b/%h want 1/00000000", if_valid, if_pc); end
    mem_lat = 2;
    @(posedge clk); #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++;
      $display("FAIL areset_pre: got req=%b want 1", imem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({imem_req, if_valid, flush} !== 3'b000) begin n_err++;
      $display("FAIL areset_flags: got %b want 000", {imem_req, if_valid, flush}); end
    n_cmp++; if ({imem_addr, if_inst} !== {RESET_PC, 32'h0}) begin n_err++;
      $display("FAIL areset_regs: got %h/%h want %h/0", imem_addr, if_inst, RESET_PC); end
  endtask

  task automatic test_random();
    logic [31:0] model_pc, p_addr, p_pc, p_inst, p_rpc;
    logic p_req, p_ack, p_valid, p_stall, p_redir, p_flush;
    logic booted, seen_redir, stale, live_ack, exp_flush;
    int r_edge, stale_ack_edge;
    model_pc = RESET_PC; booted = 1'b0; seen_redir = 1'b0; stale = 1'b0;
    r_edge = 0; stale_ack_edge = -1;
    rand_lat = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 3000; e++) begin
      @(negedge clk);
      stall          = ($urandom_range(0, 2) == 0);
      redirect_valid = booted && ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                   : $urandom;
      #2;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr; p_valid = if_valid;
      p_pc = if_pc; p_inst = if_inst; p_stall = stall; p_redir = redirect_valid;
      p_rpc = redirect_pc; p_flush = flush;
      @(posedge clk); #1;
      if (p_req) booted = 1'b1;
      if (p_req && !p_ack) begin
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, p_addr}) begin n_err++;
          $display("FAIL rnd_req_stable@%0d: got %b/%h want 1/%h", e, imem_req, imem_addr,
                   p_addr); end
      end
      live_ack = p_req && p_ack && !stale && !p_redir;
      if (p_req && p_ack && stale) begin
        stale = 1'b0;
        stale_ack_edge = e;
      end
      if (p_redir) begin
        if (p_req && !p_ack) stale = 1'b1;
        model_pc   = {p_rpc[31:2], 2'b00};
        r_edge     = e;
        seen_redir = 1'b1;
        n_cmp++; if ({if_valid, flush} !== 2'b01) begin n_err++;
          $display("FAIL rnd_redirect@%0d: got %b%b want 01", e, if_valid, flush); end
      end
      if (live_ack) begin
        n_cmp++; if (p_addr !== model_pc) begin n_err++;
          $display("FAIL rnd_fetch_addr@%0d: got %h want %h", e, p_addr, model_pc); end
        n_cmp++; if ({if_valid, if_pc, if_inst} !== {1'b1, model_pc, mem_word(model_pc)}) begin
          n_err++; $display("FAIL rnd_present@%0d: got %b/%h/%h want 1/%h/%h", e, if_valid,
                            if_pc, if_inst, model_pc, mem_word(model_pc)); end
        model_pc = model_pc + 32'd4;
      end
      if (!p_redir && p_valid && p_stall) begin
        n_cmp++; if ({if_valid, if_pc, if_inst} !== {1'b1, p_pc, p_inst}) begin n_err++;
          $display("FAIL rnd_stall@%0d: got %b/%h want 1/%h", e, if_valid, if_pc, p_pc); end
      end
      if (!p_redir && p_valid && !p_stall) begin
        n_cmp++; if ({if_valid, imem_req, imem_addr} !== {2'b01, model_pc}) begin n_err++;
          $display("FAIL rnd_consume@%0d: got %b%b/%h want 01/%h", e, if_valid, imem_req,
                   imem_addr, model_pc); end
      end
      if (imem_req && !p_req) begin
        n_cmp++; if (imem_addr !== model_pc) begin n_err++;
          $display("FAIL rnd_new_addr@%0d: got %h want %h", e, imem_addr, model_pc); end
      end
      exp_flush = seen_redir && ((e < r_edge + int'(FLUSH_DEPTH)) || stale ||
                                 (stale_ack_edge == e));
      n_cmp++; if (flush !== exp_flush) begin n_err++;
        $display("FAIL rnd_flush@%0d: got %b want %b", e, flush, exp_flush); end
      if (p_flush && !flush) begin
        n_cmp++; if (imem_req !== 1'b1) begin n_err++;
          $display("FAIL rnd_exit_req@%0d: got %b want 1", e, imem_req); end
      end
      if (flush) begin
        n_cmp++; if ({if_valid, imem_req && !stale} !== 2'b00) begin n_err++;
          $display("FAIL rnd_flush_quiet@%0d: got valid=%b req=%b want 0/%b", e, if_valid,
                   imem_req, stale); end
      end
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    rand_lat       = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect_pending();
    test_redirect_ack();
    test_back_to_back();
    test_wrap_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
